// File: rtl/fft_sink_framer_if.sv
// Sample-in / Avalon-ST-out bundle for fft_sink_framer.
// The master side drives ADC samples, config and sink_ready.
// The slave side (the framer) drives the framed beats and status.
interface fft_sink_framer_if #(
  parameter int DATA_W       = 12,
  parameter int MAX_PTS_LOG2 = 13
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_real;
  logic [DATA_W-1:0]     in_imag;
  logic                  enable;
  logic [3:0]            cfg_pts_log2;
  logic                  cfg_inverse;
  logic                  clr_ovf;
  logic                  sink_ready;
  logic                  sink_valid;
  logic                  sink_sop;
  logic                  sink_eop;
  logic [DATA_W-1:0]     sink_real;
  logic [DATA_W-1:0]     sink_imag;
  logic [1:0]            sink_error;
  logic                  inverse;
  logic [MAX_PTS_LOG2:0] fft_pts;
  logic                  ovf_sticky;
  logic [15:0]           frame_count;

  modport master (
    output in_valid, in_real, in_imag, enable, cfg_pts_log2, cfg_inverse,
           clr_ovf, sink_ready,
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
           inverse, fft_pts, ovf_sticky, frame_count
  );

  modport slave (
    input  in_valid, in_real, in_imag, enable, cfg_pts_log2, cfg_inverse,
           clr_ovf, sink_ready,
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
           inverse, fft_pts, ovf_sticky, frame_count
  );
endinterface

// File: rtl/fft_sink_framer.sv
// fft_sink_framer: ADC sample stream -> Avalon-ST frames for an FFT sink.
// A small FIFO absorbs sink_ready backpressure. A single output register
// carries sop/eop/error. An overflow during a frame closes it with an
// aborted (error=11) eop beat, so frame alignment is never lost.
// Optional: define FFT_FRAMER_OFFSET_BIN_EN to convert offset-binary ADC
// codes to two's complement at the FIFO write (MSB inverted).
module fft_sink_framer #(
  parameter int DATA_W       = 12,
  parameter int MAX_PTS_LOG2 = 13,
  parameter int FIFO_AW      = 4
) (
  input logic              clk,
  input logic              rst_n,
  fft_sink_framer_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = MAX_PTS_LOG2;
  localparam int SW    = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ABORT = 2'd2} state_t;

  state_t             st_q, st_d;
  logic [SW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [PW-1:0]      idx_q, idx_d, n_m1_q;
  logic [PW:0]        pts_q;
  logic               inv_q, ovf_q, vld_q, sop_q, eop_q, err_q;
  logic [DATA_W-1:0]  re_q, im_q;
  logic [15:0]        fc_q;

  logic               empty, full, wr_req, wr_en, ovf, accept, can_ld;
  logic               ld, ld_sop, ld_eop, ld_err, cfg_ld, fc_inc, flush;
  logic [3:0]         cfg_lg;
  logic [PW:0]        cfg_n;
  logic [DATA_W-1:0]  wr_re, wr_im;
  logic [SW-1:0]      rd_data;

`ifdef FFT_FRAMER_OFFSET_BIN_EN
  assign wr_re = bus.in_real ^ {1'b1, {(DATA_W-1){1'b0}}};
  assign wr_im = bus.in_imag ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
  assign wr_re = bus.in_real;
  assign wr_im = bus.in_imag;
`endif

  // Requested length clamped to the legal 3..MAX_PTS_LOG2 range.
  assign cfg_lg = (bus.cfg_pts_log2 < 4'd3)      ? 4'd3 :
                  (bus.cfg_pts_log2 > 4'(PW))    ? 4'(PW) : bus.cfg_pts_log2;
  assign cfg_n  = (PW+1)'(1) << cfg_lg;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign accept  = vld_q && bus.sink_ready;
  assign can_ld  = (!vld_q || accept) && !empty;
  assign rd_data = mem_q[rp_q];

  // Samples are only taken while a frame may start or is running.
  assign wr_req = bus.in_valid && (bus.enable || st_q == RUN);
  assign wr_en  = wr_req && (!full || ld) && !flush;
  assign ovf    = wr_req && full && !ld;

  assign wp_d  = wr_en ? wp_q + 1'b1 : wp_q;
  assign rp_d  = ld ? rp_q + 1'b1 : rp_q;
  assign cnt_d = cnt_q + {{FIFO_AW{1'b0}}, wr_en} - {{FIFO_AW{1'b0}}, ld};

  // Frame sequencing: decides loads into the output register and state moves.
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    ld     = 1'b0;
    ld_sop = 1'b0;
    ld_eop = 1'b0;
    ld_err = 1'b0;
    cfg_ld = 1'b0;
    fc_inc = 1'b0;
    flush  = 1'b0;
    case (st_q)
      IDLE: begin
        if (!bus.enable) begin
          flush = 1'b1;                       // discard stale samples
        end else if (can_ld) begin
          ld = 1'b1; ld_sop = 1'b1; cfg_ld = 1'b1;
          idx_d = PW'(1);
          st_d  = RUN;
        end
      end
      RUN: begin
        if (accept && eop_q) begin
          fc_inc = 1'b1;
          if (bus.enable && !empty) begin     // back-to-back next frame
            ld = 1'b1; ld_sop = 1'b1; cfg_ld = 1'b1;
            idx_d = PW'(1);
          end else begin
            st_d  = IDLE;
            flush = !bus.enable;
          end
        end else if (can_ld) begin
          ld     = 1'b1;
          ld_eop = (idx_q == n_m1_q);
          idx_d  = idx_q + 1'b1;
        end else if (ovf && !(vld_q && eop_q)) begin
          // A pending eop already closes the frame cleanly; otherwise abort.
          st_d = ABORT;
        end
      end
      ABORT: begin
        if (accept && err_q) begin
          flush = 1'b1;
          st_d  = IDLE;
        end else if (can_ld) begin
          ld = 1'b1; ld_eop = 1'b1; ld_err = 1'b1;
          ld_sop = (idx_q == '0);
          idx_d  = idx_q + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // FIFO pointers and occupancy; flush returns them to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= {wr_re, wr_im};
  end

  // State, point index, latched config, output beat register and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      idx_q  <= '0;
      n_m1_q <= '1;
      pts_q  <= (PW+1)'(1) << PW;
      inv_q  <= 1'b0;
      vld_q  <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      err_q  <= 1'b0;
      re_q   <= '0;
      im_q   <= '0;
      fc_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      if (cfg_ld) begin
        n_m1_q <= PW'(cfg_n - (PW+1)'(1));
        pts_q  <= cfg_n;
        inv_q  <= bus.cfg_inverse;
      end
      if (ld) begin
        vld_q <= 1'b1;
        sop_q <= ld_sop;
        eop_q <= ld_eop;
        err_q <= ld_err;
        re_q  <= rd_data[SW-1:DATA_W];
        im_q  <= rd_data[DATA_W-1:0];
      end else if (accept) begin
        vld_q <= 1'b0;
        sop_q <= 1'b0;
        eop_q <= 1'b0;
        err_q <= 1'b0;
      end
      if (fc_inc) fc_q <= fc_q + 16'd1;
      if (ovf)              ovf_q <= 1'b1;    // set beats clear
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign bus.sink_valid  = vld_q;
  assign bus.sink_sop    = sop_q;
  assign bus.sink_eop    = eop_q;
  assign bus.sink_error  = {2{err_q}};
  assign bus.sink_real   = re_q;
  assign bus.sink_imag   = im_q;
  assign bus.inverse     = inv_q;
  assign bus.fft_pts     = pts_q;
  assign bus.ovf_sticky  = ovf_q;
  assign bus.frame_count = fc_q;
endmodule

// File: tb/tb_fft_sink_framer.sv
// Directed bench for fft_sink_framer: clamp table plus hand-written
// sequences for streaming, backpressure, overflow, config latch, enable/reset.
module tb_fft_sink_framer;
  localparam int DW = 12;
  localparam int PL = 13;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_sink_framer_if #(.DATA_W(DW), .MAX_PTS_LOG2(PL)) bus();

  fft_sink_framer #(.DATA_W(DW), .MAX_PTS_LOG2(PL), .FIFO_AW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          sop;
    logic          eop;
    logic [1:0]    err;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          inv;
    logic [PL:0]   pts;
  } beat_t;

  typedef struct {
    logic [3:0] cfg;
    logic       inv;
    logic [PL:0] pts;
  } vec_t;

  beat_t         acc_q[$];
  vec_t          tbl[6];
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] smp;

  function automatic logic [DW-1:0] xf(input logic [DW-1:0] v);
`ifdef FFT_FRAMER_OFFSET_BIN_EN
    return v ^ 12'h800;
`else
    return v;
`endif
  endfunction

  function automatic logic [31:0] mkb(input logic s, input logic e, input logic [1:0] er,
                                       input logic [DW-1:0] d);
    return {4'd0, s, e, er, xf(d), xf(d ^ 12'h5A5)};
  endfunction

  function automatic logic [31:0] pk(input beat_t b);
    return {4'd0, b.sop, b.eop, b.err, b.re, b.im};
  endfunction

  function automatic beat_t cur();
    beat_t b;
    b.sop = bus.sink_sop;  b.eop = bus.sink_eop;  b.err = bus.sink_error;
    b.re  = bus.sink_real; b.im  = bus.sink_imag;
    b.inv = bus.inverse;   b.pts = bus.fft_pts;
    return b;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: log the beat accepted at this edge, check stalled beats hold,
  // then advance the ramp if a sample was offered.
  task automatic tick();
    beat_t b;
    bit    st;
    b  = cur();
    st = bus.sink_valid && !bus.sink_ready;
    if (bus.sink_valid && bus.sink_ready) acc_q.push_back(b);
    @(posedge clk); #1;
    if (st) check("stall_hold", {3'd0, bus.sink_valid, pk(cur())}, {3'd0, 1'b1, pk(b)});
    if (bus.in_valid) smp = smp + 1'b1;
    bus.in_real = smp;
    bus.in_imag = smp ^ 12'h5A5;
  endtask

  task automatic run_until(input int n, input int budget, input string nm);
    int c = 0;
    while (acc_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (acc_q.size() < n) check(nm, acc_q.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.enable = 1'b0; bus.cfg_pts_log2 = 4'd3;
    bus.cfg_inverse = 1'b0; bus.clr_ovf = 1'b0; bus.sink_ready = 1'b0;
    smp = '0; bus.in_real = '0; bus.in_imag = 12'h5A5;
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'd0,  1'b0, 14'd8};
    tbl[1] = '{4'd3,  1'b1, 14'd8};
    tbl[2] = '{4'd4,  1'b0, 14'd16};
    tbl[3] = '{4'd7,  1'b1, 14'd128};
    tbl[4] = '{4'd13, 1'b0, 14'd8192};
    tbl[5] = '{4'd15, 1'b1, 14'd8192};

    // Reset state, latency, ramp framing, back-to-back frames.
    do_reset();
    check("rst_sink", {bus.sink_valid, bus.sink_sop, bus.sink_eop, bus.sink_error}, 0);
    check("rst_pts", bus.fft_pts, 8192);
    check("rst_misc", {bus.inverse, bus.ovf_sticky, bus.frame_count}, 0);
    bus.enable = 1'b1; bus.cfg_pts_log2 = 4'd3; bus.sink_ready = 1'b1;
    tick();
    bus.in_valid = 1'b1;
    tick();
    check("lat_t1", bus.sink_valid, 0);
    tick();
    check("lat_t2", bus.sink_valid, 1);
    check("ramp_pts", bus.fft_pts, 8);
    run_until(24, 100, "ramp_timeout");
    check("ramp_fc", bus.frame_count, 3);
    for (int i = 0; i < 24 && i < acc_q.size(); i++)
      check("ramp_beat", pk(acc_q[i]), mkb(i % 8 == 0, i % 8 == 7, 2'b00, DW'(i)));

    // Backpressure: ready 1,0,1,0 with 50% in_valid, 16-point frame.
    do_reset();
    bus.enable = 1'b1; bus.cfg_pts_log2 = 4'd4;
    for (int c = 0; c < 200 && acc_q.size() < 16; c++) begin
      bus.in_valid   = (c % 4) < 2;
      bus.sink_ready = (c % 2) == 0;
      tick();
    end
    if (acc_q.size() < 16) check("bp_timeout", acc_q.size(), 16);
    for (int i = 0; i < 16 && i < acc_q.size(); i++)
      check("bp_beat", pk(acc_q[i]), mkb(i == 0, i == 15, 2'b00, DW'(i)));
    check("bp_no_ovf", bus.ovf_sticky, 0);

    // Overflow in a 64-point frame while the core stalls.
    do_reset();
    bus.enable = 1'b1; bus.cfg_pts_log2 = 4'd6; bus.sink_ready = 1'b1; bus.in_valid = 1'b1;
    repeat (10) tick();
    bus.sink_ready = 1'b0;
    repeat (20) tick();
    check("ovf_set", bus.ovf_sticky, 1);
    acc_q.delete();
    bus.sink_ready = 1'b1;
    run_until(3, 40, "ovf_timeout");
    if (acc_q.size() >= 3) begin
      check("ovf_pending", {acc_q[0].eop, acc_q[0].err}, 3'b000);
      check("ovf_abort_beat", {acc_q[1].eop, acc_q[1].err}, 3'b111);
      check("ovf_new_sop", {acc_q[2].sop, acc_q[2].err}, 3'b100);
    end
    check("ovf_fc", bus.frame_count, 0);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf_clr", bus.ovf_sticky, 0);

    // Config changed mid-frame takes effect at the next sop.
    do_reset();
    bus.enable = 1'b1; bus.cfg_pts_log2 = 4'd4; bus.sink_ready = 1'b1; bus.in_valid = 1'b1;
    run_until(5, 40, "cfg_timeout_a");
    bus.cfg_pts_log2 = 4'd5; bus.cfg_inverse = 1'b1;
    run_until(48, 200, "cfg_timeout_b");
    if (acc_q.size() >= 48) begin
      int neop = 0;
      check("cfg_f1_end", {acc_q[15].eop, acc_q[15].inv, acc_q[15].pts}, {1'b1, 1'b0, 14'd16});
      check("cfg_f2_sop", {acc_q[16].sop, acc_q[16].inv, acc_q[16].pts}, {1'b1, 1'b1, 14'd32});
      check("cfg_f2_end", {acc_q[47].eop, acc_q[46].eop}, 2'b10);
      for (int i = 0; i < 48; i++) if (acc_q[i].eop) neop++;
      check("cfg_eops", neop, 2);
    end

    // Clamp table: first beat of a fresh stream.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus.cfg_pts_log2 = tbl[v].cfg; bus.cfg_inverse = tbl[v].inv;
      bus.enable = 1'b1; bus.sink_ready = 1'b1; bus.in_valid = 1'b1;
      run_until(1, 20, "clamp_timeout");
      if (acc_q.size() >= 1)
        check("clamp", {acc_q[0].sop, acc_q[0].inv, acc_q[0].pts, acc_q[0].re},
              {1'b1, tbl[v].inv, tbl[v].pts, xf(12'h000)});
    end

    // Enable dropped at beat 5 of 8: frame completes, then idle.
    do_reset();
    bus.enable = 1'b1; bus.cfg_pts_log2 = 4'd3; bus.sink_ready = 1'b1; bus.in_valid = 1'b1;
    run_until(5, 40, "en_timeout");
    bus.enable = 1'b0;
    repeat (20) tick();
    check("en_beats", acc_q.size(), 8);
    if (acc_q.size() >= 8) check("en_last_eop", acc_q[7].eop, 1);
    check("en_fc", bus.frame_count, 1);
    check("en_idle", bus.sink_valid, 0);

    // Asynchronous reset mid-frame.
    bus.enable = 1'b1;
    acc_q.delete();
    run_until(3, 40, "rst_timeout");
    rst_n = 1'b0;
    #1;
    check("arst_sink", {bus.sink_valid, bus.sink_sop, bus.sink_eop, bus.sink_error}, 0);
    check("arst_pts", bus.fft_pts, 8192);
    check("arst_misc", {bus.inverse, bus.ovf_sticky, bus.frame_count}, 0);

`ifdef FFT_FRAMER_OFFSET_BIN_EN
    // Offset-binary conversion at the FIFO write.
    do_reset();
    bus.enable = 1'b1; bus.cfg_pts_log2 = 4'd3; bus.sink_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_real = 12'h800;
    tick();
    bus.in_real = 12'h000;
    tick();
    bus.in_valid = 1'b0;
    run_until(2, 20, "obin_timeout");
    if (acc_q.size() >= 2) begin
      check("obin_800", acc_q[0].re, 12'h000);
      check("obin_000", acc_q[1].re, 12'h800);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
